// File: rtl/fp16_mac_pkg.sv
// Shared widths and the aligned-operand record for the FP16 MAC accumulate path.
// The alignment stage consumes these as its default geometry.
package fp16_mac_pkg;

    localparam int EXP_W     = 8;
    localparam int MAN_W     = 22;
    localparam int GRS_W     = 3;
    localparam int SH_W      = 5;
    localparam int FP16_BIAS = 15;
    localparam int ALIGN_W   = MAN_W + GRS_W;

    typedef struct packed {
        logic               sign_big;
        logic               sign_small;
        logic [EXP_W-1:0]   exp;
        logic [ALIGN_W-1:0] man_big;
        logic [ALIGN_W-1:0] man_small;
        logic               eff_sub;
    } align_t;

endpackage

// File: rtl/sticky_rshift.sv
// Combinational barrel right-shift; every bit shifted out is ORed into bit 0
// so the downstream rounder still sees that a non-zero tail was discarded.
module sticky_rshift #(
    parameter int W    = 25,
    parameter int SH_W = 5
) (
    input  logic [W-1:0]    data_i,
    input  logic [SH_W-1:0] sh_i,
    output logic [W-1:0]    data_o
);

    logic lost;

    always_comb begin
        lost = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i < int'(sh_i)) begin
                lost = lost | data_i[i];
            end
        end
        data_o    = data_i >> sh_i;
        data_o[0] = data_o[0] | lost;
    end

endmodule

// File: rtl/fp16_mac_align_stage.sv
// Two-stage operand alignment: S1 orders the operands by magnitude and computes
// the clamped shift, S2 right-shifts the smaller mantissa keeping guard/round/sticky.
module fp16_mac_align_stage
    import fp16_mac_pkg::*;
#(
    parameter int EXP_W = fp16_mac_pkg::EXP_W,
    parameter int MAN_W = fp16_mac_pkg::MAN_W,
    parameter int SH_W  = fp16_mac_pkg::SH_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               a_sign,
    input  logic [EXP_W-1:0]   a_exp,
    input  logic [MAN_W-1:0]   a_man,
    input  logic               b_sign,
    input  logic [EXP_W-1:0]   b_exp,
    input  logic [MAN_W-1:0]   b_man,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign_big,
    output logic               out_sign_small,
    output logic [EXP_W-1:0]   out_exp,
    output logic [MAN_W+2:0]   out_man_big,
    output logic [MAN_W+2:0]   out_man_small,
    output logic               out_eff_sub
);

    localparam int AW = MAN_W + GRS_W;

    // Handshake: a stage may load when it is empty or its contents move on this
    // cycle; transfers happen on valid & ready in the same cycle.
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign s1_valid_d = s1_adv ? in_valid   : s1_valid_q;
    assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

    logic [EXP_W:0]   diff;
    logic [EXP_W:0]   mag;
    logic             a_lt;
    logic             a_big;
    logic [SH_W-1:0]  sh_d;

    always_comb begin
        diff  = {1'b0, a_exp} - {1'b0, b_exp};
        a_lt  = diff[EXP_W];
        a_big = !a_lt && ((diff != '0) || (a_man >= b_man));
        mag   = a_lt ? ({1'b0, b_exp} - {1'b0, a_exp}) : diff;
        if (mag >= (EXP_W+1)'(AW)) begin
            sh_d = SH_W'(AW);
        end else begin
            sh_d = mag[SH_W-1:0];
        end
    end

    logic              s1_sign_big_q, s1_sign_small_q, s1_eff_sub_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [MAN_W-1:0]  s1_man_big_q, s1_man_small_q;
    logic [SH_W-1:0]   s1_sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_sign_big_q   <= 1'b0;
            s1_sign_small_q <= 1'b0;
            s1_eff_sub_q    <= 1'b0;
            s1_exp_q        <= '0;
            s1_man_big_q    <= '0;
            s1_man_small_q  <= '0;
            s1_sh_q         <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_adv && in_valid) begin
                s1_sign_big_q   <= a_big ? a_sign : b_sign;
                s1_sign_small_q <= a_big ? b_sign : a_sign;
                s1_eff_sub_q    <= a_sign ^ b_sign;
                s1_exp_q        <= a_big ? a_exp : b_exp;
                s1_man_big_q    <= a_big ? a_man : b_man;
                s1_man_small_q  <= a_big ? b_man : a_man;
                s1_sh_q         <= sh_d;
            end
        end
    end

    logic [AW-1:0] aligned_small;

    sticky_rshift #(
        .W    (AW),
        .SH_W (SH_W)
    ) u_sticky_rshift (
        .data_i ({s1_man_small_q, {GRS_W{1'b0}}}),
        .sh_i   (s1_sh_q),
        .data_o (aligned_small)
    );

    align_t s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_adv && s1_valid_q) begin
                s2_q.sign_big   <= s1_sign_big_q;
                s2_q.sign_small <= s1_sign_small_q;
                s2_q.exp        <= s1_exp_q;
                s2_q.man_big    <= {s1_man_big_q, {GRS_W{1'b0}}};
                s2_q.man_small  <= aligned_small;
                s2_q.eff_sub    <= s1_eff_sub_q;
            end
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_sign_big   = s2_q.sign_big;
    assign out_sign_small = s2_q.sign_small;
    assign out_exp        = s2_q.exp;
    assign out_man_big    = s2_q.man_big;
    assign out_man_small  = s2_q.man_small;
    assign out_eff_sub    = s2_q.eff_sub;

endmodule
